// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two 4*NIBBLES-bit operands with a single 4-bit
// ripple-carry adder, one nibble per cycle, least significant nibble first.
// Operands enter on a valid/ready handshake; the registered sum and carry-out
// leave on a second valid/ready handshake and hold until the next result.

// ripplecarry: 4-bit ripple-carry adder built from four full-adder cells.
module ripplecarry (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_c4
);
    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_c4 = w_c[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy
);
    localparam int W  = 4 * NIBBLES;
    // Index wide enough to hold NIBBLES-1 even when NIBBLES is 1.
    localparam int IW = $clog2(NIBBLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [W-1:0]  r_work;
    logic [W-1:0]  r_sum;
    logic          r_carry;
    logic          r_cout;
    logic [IW-1:0] r_idx;

    logic [3:0]    w_nib_sum;
    logic          w_c4;
    logic [W-1:0]  w_work_next;
    logic          w_last;

    // The one shared 4-bit adder always sees the low nibble of each shift register.
    ripplecarry u_rca (
        .i_a   (r_a_sh[3:0]),
        .i_b   (r_b_sh[3:0]),
        .i_cin (r_carry),
        .o_sum (w_nib_sum),
        .o_c4  (w_c4)
    );

    // New nibble enters at the top; after NIBBLES steps nibble 0 sits at the bottom.
    if (NIBBLES == 1) begin : g_work_one
        assign w_work_next = w_nib_sum;
    end else begin : g_work_many
        assign w_work_next = {w_nib_sum, r_work[W-1:4]};
    end

    assign w_last = (r_idx == LAST_IDX);
    assign sum    = r_sum;
    assign cout   = r_cout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; handshake flags are decoded from the state register alone.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, step one nibble per RUN cycle, publish on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_c4;
                    r_a_sh  <= r_a_sh >> 4;
                    r_b_sh  <= r_b_sh >> 4;
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        r_sum  <= w_work_next;
                        r_cout <= w_c4;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: three instances (NIBBLES = 4, 1, 8) checked every cycle
// against a transaction-level model, plus directed vectors on the 4-nibble instance.
module tb_nibble_serial_adder;
    localparam int NCFG = 3;

    function automatic int nib(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [32:0] mask_of(input int i);
        return (33'd1 << (4 * nib(i))) - 33'd1;
    endfunction

    logic        clk = 1'b0;
    logic        rst_x       [NCFG];
    logic        in_valid_x  [NCFG];
    logic        out_ready_x [NCFG];
    logic        cin_x       [NCFG];
    logic [31:0] a_x         [NCFG];
    logic [31:0] b_x         [NCFG];
    logic        ir_x        [NCFG];
    logic        ov_x        [NCFG];
    logic        busy_x      [NCFG];
    logic [32:0] res_x       [NCFG];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Model: -1 = waiting for operands, 0..N-1 = nibbles consumed, N = result presented.
    int          m_cnt  [NCFG] = '{-1, -1, -1};
    logic [32:0] m_pend [NCFG];
    logic [32:0] m_res  [NCFG] = '{33'd0, 33'd0, 33'd0};
    int          hs_cnt [NCFG] = '{0, 0, 0};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int N = nib(gi);
        localparam int W = 4 * N;
        logic [W-1:0] w_sum;
        logic         w_cout;
        logic         w_ir;
        logic         w_ov;
        logic         w_busy;

        nibble_serial_adder #(.NIBBLES(N)) dut (
            .clk       (clk),
            .rst_n     (rst_x[gi]),
            .in_valid  (in_valid_x[gi]),
            .in_ready  (w_ir),
            .a         (a_x[gi][W-1:0]),
            .b         (b_x[gi][W-1:0]),
            .cin       (cin_x[gi]),
            .out_valid (w_ov),
            .out_ready (out_ready_x[gi]),
            .sum       (w_sum),
            .cout      (w_cout),
            .busy      (w_busy)
        );

        assign ir_x[gi]   = w_ir;
        assign ov_x[gi]   = w_ov;
        assign busy_x[gi] = w_busy;
        assign res_x[gi]  = 33'({w_cout, w_sum});
    end

    task automatic check(input string nm, input int inst, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h", nm, inst, act, exp);
        end
    endtask

    // Model update: exact arithmetic on accept, result visible N cycles later, released on out_ready.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NCFG; i++) begin
            if (!rst_x[i]) begin
                m_cnt[i] <= -1;
                m_res[i] <= '0;
            end else if (m_cnt[i] < 0) begin
                if (in_valid_x[i]) begin
                    m_cnt[i]  <= 0;
                    m_pend[i] <= (33'(a_x[i]) & mask_of(i)) + (33'(b_x[i]) & mask_of(i)) + 33'(cin_x[i]);
                end
            end else if (m_cnt[i] < nib(i)) begin
                m_cnt[i] <= m_cnt[i] + 1;
                if (m_cnt[i] + 1 == nib(i)) begin
                    m_res[i] <= m_pend[i];
                end
            end else if (out_ready_x[i]) begin
                m_cnt[i]  <= -1;
                hs_cnt[i] <= hs_cnt[i] + 1;
            end
        end
    end

    // Compare all outputs of every instance against the model on each falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < NCFG; i++) begin
            if (!rst_x[i]) begin
                check("rst_in_ready",  i, 33'(ir_x[i]),   33'd1);
                check("rst_out_valid", i, 33'(ov_x[i]),   33'd0);
                check("rst_busy",      i, 33'(busy_x[i]), 33'd0);
                check("rst_result",    i, res_x[i],       33'd0);
            end else begin
                check("cyc_in_ready",  i, 33'(ir_x[i]),   33'(m_cnt[i] < 0));
                check("cyc_out_valid", i, 33'(ov_x[i]),   33'(m_cnt[i] == nib(i)));
                check("cyc_busy",      i, 33'(busy_x[i]), 33'(m_cnt[i] >= 0));
                check("cyc_result",    i, res_x[i],       m_res[i]);
            end
        end
    end

    // One operation on the 4-nibble instance with a hand-computed {cout,sum}.
    task automatic op4(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       input logic [16:0] exp, input logic hold_rdy, input string nm);
        int k;
        @(posedge clk); #1;
        a_x[0]         = 32'(ta);
        b_x[0]         = 32'(tb_v);
        cin_x[0]       = tc;
        in_valid_x[0]  = 1'b1;
        out_ready_x[0] = hold_rdy;
        @(posedge clk); #1;
        in_valid_x[0]  = 1'b0;
        k = 0;
        while (ov_x[0] !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check({nm, "_latency"}, 0, 33'(k), 33'd4);
        check({nm, "_result"},  0, res_x[0], 33'(exp));
        check({nm, "_model"},   0, m_res[0], 33'(exp));
        if (!hold_rdy) begin
            for (int c = 0; c < 5; c++) begin
                a_x[0]        = $urandom;
                b_x[0]        = $urandom;
                cin_x[0]      = 1'($urandom_range(0, 1));
                in_valid_x[0] = 1'b1;
                @(posedge clk); #1;
                check({nm, "_bp_valid"}, 0, 33'(ov_x[0]), 33'd1);
                check({nm, "_bp_ready"}, 0, 33'(ir_x[0]), 33'd0);
                check({nm, "_bp_hold"},  0, res_x[0],     33'(exp));
            end
            in_valid_x[0]  = 1'b0;
            out_ready_x[0] = 1'b1;
        end
        @(posedge clk); #1;
        check({nm, "_ready_back"}, 0, 33'(ir_x[0]), 33'd1);
        check({nm, "_valid_drop"}, 0, 33'(ov_x[0]), 33'd0);
        check({nm, "_kept"},       0, res_x[0],     33'(exp));
        $display("op %s a=%h b=%h cin=%0d -> %h latency=%0d", nm, ta, tb_v, tc, res_x[0], k);
    endtask

    // Back-to-back random operations with in_valid and out_ready held high.
    task automatic rand_run(input int i, input int n);
        int base, got, guard, t_first, t_last;
        base    = hs_cnt[i];
        got     = 0;
        guard   = 0;
        t_first = 0;
        t_last  = 0;
        in_valid_x[i]  = 1'b1;
        out_ready_x[i] = 1'b1;
        while (got < n && guard < n * (nib(i) + 2) + 100) begin
            a_x[i]   = $urandom;
            b_x[i]   = $urandom;
            cin_x[i] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
            if (hs_cnt[i] - base != got) begin
                got = hs_cnt[i] - base;
                if (got == 1) t_first = cyc;
                t_last = cyc;
            end
        end
        in_valid_x[i] = 1'b0;
        check("rand_count", i, 33'(got), 33'(n));
        check("rand_rate",  i, 33'(t_last - t_first), 33'((n - 1) * (nib(i) + 2)));
        $display("random run NIBBLES=%0d ops=%0d cycles_between_first_last=%0d", nib(i), got, t_last - t_first);
    endtask

    initial begin
        for (int i = 0; i < NCFG; i++) begin
            rst_x[i]       = 1'b1;
            in_valid_x[i]  = 1'b0;
            out_ready_x[i] = 1'b0;
            cin_x[i]       = 1'b0;
            a_x[i]         = '0;
            b_x[i]         = '0;
        end
        #1;
        // Reset asserted between clock edges with random inputs.
        for (int i = 0; i < NCFG; i++) begin
            rst_x[i]       = 1'b0;
            in_valid_x[i]  = 1'b1;
            out_ready_x[i] = 1'($urandom_range(0, 1));
            cin_x[i]       = 1'($urandom_range(0, 1));
            a_x[i]         = $urandom;
            b_x[i]         = $urandom;
        end
        #1;
        for (int i = 0; i < NCFG; i++) begin
            check("async_rst_in_ready",  i, 33'(ir_x[i]),   33'd1);
            check("async_rst_out_valid", i, 33'(ov_x[i]),   33'd0);
            check("async_rst_busy",      i, 33'(busy_x[i]), 33'd0);
            check("async_rst_result",    i, res_x[i],       33'd0);
        end
        $display("reset asserted: in_ready=%0d out_valid=%0d busy=%0d result=%h", ir_x[0], ov_x[0], busy_x[0], res_x[0]);
        @(posedge clk); #1;
        for (int i = 0; i < NCFG; i++) begin
            in_valid_x[i]  = 1'b0;
            out_ready_x[i] = 1'b1;
        end
        @(posedge clk); #1;
        for (int i = 0; i < NCFG; i++) rst_x[i] = 1'b1;

        op4(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b1, "basic");
        op4(16'hFFFF, 16'h0000, 1'b1, 17'h10000, 1'b1, "carry_ffff_0000");
        op4(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b1, "carry_ffff_ffff");
        op4(16'h0FFF, 16'h0001, 1'b0, 17'h01000, 1'b1, "carry_0fff_0001");
        op4(16'hA5C3, 16'h5A3D, 1'b0, 17'h10000, 1'b0, "backpressure");

        // Reset two cycles into RUN: the partial work and the previous result vanish.
        @(posedge clk); #1;
        a_x[0]        = 32'h0000_1234;
        b_x[0]        = 32'h0000_4321;
        cin_x[0]      = 1'b1;
        in_valid_x[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_x[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrun_busy_before", 0, 33'(busy_x[0]), 33'd1);
        rst_x[0] = 1'b0;
        #1;
        check("midrun_rst_in_ready",  0, 33'(ir_x[0]),   33'd1);
        check("midrun_rst_out_valid", 0, 33'(ov_x[0]),   33'd0);
        check("midrun_rst_busy",      0, 33'(busy_x[0]), 33'd0);
        check("midrun_rst_result",    0, res_x[0],       33'd0);
        $display("mid-run reset: in_ready=%0d out_valid=%0d busy=%0d result=%h", ir_x[0], ov_x[0], busy_x[0], res_x[0]);
        @(posedge clk); #1;
        rst_x[0] = 1'b1;
        op4(16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b1, "after_reset");

        fork
            rand_run(0, 1000);
            rand_run(1, 1000);
            rand_run(2, 1000);
        join

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog[0] actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
